eaglesong_absorb_ctrl: RTL
==========================

# eaglesong_absorb_ctrl

Sequencer for a single-message Eaglesong hash. It accepts messages of up to 32 bytes and owns the 16-word sponge state. It drives the combinational absorb datapath (`eaglesong_absorb_comb`) and an external multi-cycle permutation unit through a start/done handshake. It returns the 256-bit squeezed digest over a valid/ready port, and sits between the host message interface and the hashing datapath.

## Interface
- No parameters. Rate is fixed at 256 bits (8 words), capacity at 256 bits (8 words), and maximum message length at 32 bytes.
- `clk` in 1 — single clock; all state updates on its rising edge.
- `rst_n` in 1 — reset, asynchronous and active-low.
- `msg_valid` in 1 — a message is offered.
- `msg_ready` out 1 — controller can accept a message.
- `msg_data` in 256 — message bytes; byte b is `[8b+7:8b]`.
- `msg_len` in 7 — message length in bytes; legal range 1..32.
- `abort` in 1 — synchronous abort; returns the controller to IDLE.
- `absorb_state_in` out 256 — state words 0..7 to the absorb datapath; word w is `[32w+31:32w]`.
- `absorb_input_val` out 256 — latched message to the absorb datapath.
- `absorb_len` out 7 — latched `msg_len`.
- `absorb_round_num` out 8 — current absorb round, 0 or 1.
- `absorb_state_out` in 256 — absorb datapath result, words 0..7.
- `perm_start` out 1 — one-cycle start pulse to the permutation unit.
- `perm_state_in` out 512 — full state to the permutation unit; word w is `[32w+31:32w]`.
- `perm_done` in 1 — one-cycle completion pulse from the permutation unit.
- `perm_state_out` in 512 — permuted state; valid when `perm_done`=1.
- `digest_valid` out 1 — digest available.
- `digest_ready` in 1 — host accepts the digest.
- `digest` out 256 — state words 0..7; word 0 is at `[31:0]`.
- `len_err` out 1 — one-cycle pulse when an offered `msg_len` is illegal.
- `busy` out 1 — high in every state except IDLE.
- `digest_count` out 16 — number of digests delivered; wraps from 0xFFFF to 0.

## Operation
The controller is a state machine with states IDLE, ABSORB, PERM_START, PERM_WAIT and OUT.

**IDLE**
- `msg_ready`=1.
- On `msg_valid`&`msg_ready` with `msg_len` in 1..32:
  - latch `msg_data` and `msg_len`;
  - clear all 16 state words;
  - set round=0;
  - go to ABSORB.
- On `msg_valid`&`msg_ready` with `msg_len`=0 or >32:
  - pulse `len_err` in the following cycle;
  - discard the message;
  - stay in IDLE.

**ABSORB** (exactly 1 cycle)
- State words 0..7 <= `absorb_state_out`.
- Words 8..15 are unchanged.
- Go to PERM_START.

**PERM_START** (exactly 1 cycle)
- `perm_start`=1.
- Go to PERM_WAIT.

**PERM_WAIT**
- Wait for `perm_done`.
- On `perm_done`:
  - all 16 words <= `perm_state_out`;
  - if round=0 and latched len=32: round<=1, go to ABSORB (the delimiter-only block);
  - otherwise go to OUT.
- `perm_done` is sampled only in PERM_WAIT; it is ignored in every other state.

**OUT**
- `digest_valid`=1.
- `digest` = state words 0..7, held stable until accepted.
- On `digest_ready`: `digest_count`++ and go to IDLE.

**Continuous datapath drives**
- `absorb_state_in` = words 0..7.
- `absorb_input_val` = latched data.
- `absorb_len` = latched len.
- `absorb_round_num` = {7'b0, round}.
- `perm_state_in` = all 16 words.

**abort**
- Taking effect on the next edge from any state: go to IDLE and clear round.
- The latched state is left as-is.
- A `perm_done` arriving after the abort is ignored.
- `abort` has priority over every other transition, including `perm_done` and `digest_ready` in the same cycle.

## Timing
- **Reset values:**
  - `msg_ready`=1;
  - `perm_start`=0, `digest_valid`=0, `len_err`=0, `busy`=0;
  - `digest_count`=0;
  - all state words, latched data, len and round = 0;
  - state = IDLE.
- **Reset mid-operation:** immediate return to IDLE with the reset values above; no digest is emitted.
- **Cycle sequence for len<32,** with the message accepted at edge T:
  - ABSORB during cycle T..T+1;
  - `perm_start` high during cycle T+1..T+2;
  - with `perm_done` sampled at edge D, `digest_valid` is high from D.
- **Minimum latency,** from accept to `digest_valid`, with `perm_done` one cycle after `perm_start`: 3 cycles for len<32 and 6 cycles for len=32.
- `msg_ready` is combinationally equal to (state==IDLE); a message is never accepted while busy.
- `digest_valid` is not withdrawn before `digest_ready` unless `abort` or reset occurs.
- Back-to-back operation: after the digest handshake at edge E, a new message can be accepted at edge E+1.

## Test plan
- **Short message.** Stimulus: `msg_len`=5, `msg_data` bytes = 01 02 03 04 05.
  - Required: exactly one `perm_start`, with `absorb_round_num`=0 and `absorb_len`=5 during ABSORB.
  - Required: `digest` equals the C-model Eaglesong digest of those 5 bytes.
  - Required: `digest_count`=1.
- **32-byte message.** Stimulus: `msg_len`=32, bytes = 00..1F.
  - Required: two `perm_start` pulses, the first with round 0 and the second with round 1.
  - Required: digest matches the C model.
  - Required: minimum latency of 6 cycles when `perm_done` is returned 1 cycle after `perm_start`.
- **Illegal length.** Stimulus: `msg_len`=0, then `msg_len`=33.
  - Required: a `len_err` pulse each time; `busy` stays 0; no `perm_start`.
- **Backpressure.** Stimulus: hold `digest_ready`=0 for 10 cycles after `digest_valid` rises.
  - Required: `digest` is stable and `msg_ready`=0 throughout.
  - Required: after the handshake, a new message is accepted one cycle later.
- **Abort in flight.** Stimulus: assert `abort` in PERM_WAIT, then return `perm_done` 3 cycles later.
  - Required: state is IDLE and `busy`=0 one cycle after the abort.
  - Required: the late `perm_done` causes no `digest_valid`.
  - Required: the next message hashes correctly.
- **Reset in flight.** Stimulus: drop `rst_n` during ABSORB.
  - Required: all outputs take their reset values immediately; `digest_count`=0.

Source files
------------

// File: rtl/eaglesong_absorb_ctrl.sv
// Eaglesong single-message sequencer: owns the 16-word sponge state, drives the
// combinational absorb datapath and handshakes with a multi-cycle permutation unit.
module eaglesong_absorb_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [255:0] msg_data,
    input  logic [6:0]   msg_len,
    input  logic         abort,
    output logic [255:0] absorb_state_in,
    output logic [255:0] absorb_input_val,
    output logic [6:0]   absorb_len,
    output logic [7:0]   absorb_round_num,
    input  logic [255:0] absorb_state_out,
    output logic         perm_start,
    output logic [511:0] perm_state_in,
    input  logic         perm_done,
    input  logic [511:0] perm_state_out,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest,
    output logic         len_err,
    output logic         busy,
    output logic [15:0]  digest_count
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ABSORB     = 3'd1,
        S_PERM_START = 3'd2,
        S_PERM_WAIT  = 3'd3,
        S_OUT        = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic           round_q, round_d;
    logic [6:0]     len_q, len_d;
    logic [255:0]   data_q, data_d;
    logic [511:0]   st_q, st_d;
    logic           len_err_q, len_err_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           len_ok_s;

    assign len_ok_s = (msg_len != 7'd0) && (msg_len <= 7'd32);

    // State register and all held context
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            round_q   <= 1'b0;
            len_q     <= 7'd0;
            data_q    <= 256'd0;
            st_q      <= 512'd0;
            len_err_q <= 1'b0;
            cnt_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            len_q     <= len_d;
            data_q    <= data_d;
            st_q      <= st_d;
            len_err_q <= len_err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        len_d     = len_q;
        data_d    = data_q;
        st_d      = st_q;
        len_err_d = 1'b0;
        cnt_d     = cnt_q;
        if (abort) begin
            state_d = S_IDLE;
            round_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (msg_valid) begin
                        if (len_ok_s) begin
                            data_d  = msg_data;
                            len_d   = msg_len;
                            st_d    = 512'd0;
                            round_d = 1'b0;
                            state_d = S_ABSORB;
                        end else begin
                            len_err_d = 1'b1;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ABSORB: begin
                    st_d[255:0] = absorb_state_out;
                    state_d     = S_PERM_START;
                end
                S_PERM_START: begin
                    state_d = S_PERM_WAIT;
                end
                S_PERM_WAIT: begin
                    if (perm_done) begin
                        st_d = perm_state_out;
                        // A full 32-byte block needs a second, delimiter-only absorb
                        if (!round_q && (len_q == 7'd32)) begin
                            round_d = 1'b1;
                            state_d = S_ABSORB;
                        end else begin
                            state_d = S_OUT;
                        end
                    end else begin
                        state_d = S_PERM_WAIT;
                    end
                end
                S_OUT: begin
                    if (digest_ready) begin
                        cnt_d   = cnt_q + 16'd1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_OUT;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    round_d = 1'b0;
                end
            endcase
        end
    end

    assign msg_ready        = (state_q == S_IDLE);
    assign busy             = (state_q != S_IDLE);
    assign perm_start       = (state_q == S_PERM_START);
    assign digest_valid     = (state_q == S_OUT);
    assign len_err          = len_err_q;
    assign digest_count     = cnt_q;
    assign digest           = st_q[255:0];
    assign absorb_state_in  = st_q[255:0];
    assign absorb_input_val = data_q;
    assign absorb_len       = len_q;
    assign absorb_round_num = {7'd0, round_q};
    assign perm_state_in    = st_q;

endmodule
